ttt_processor_bank: RTL and testbench

- Bank of NUM_PROCESSORS token processors that forms the processor side of the tt_um_jleugeri_ttt_network event interface.
- Holds per-processor good/bad token counters and thresholds, and scans processors round-robin.
- On each start/stop transition it issues one event (valid_in/source_id/token_startstop) to the network.
- It then absorbs the network's streamed token deltas (valid_out/target_id/new_*_tokens) until done.

---
 rtl/ttt_processor_bank.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_ttt_processor_bank.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_processor_bank.sv
// ttt_processor_bank
// ------------------
// This is the processor side of the tt_um_jleugeri_ttt_network event interface.
// It holds a bank of token processors. Each processor has a signed good-token
// counter, a signed bad-token counter, a good threshold, a bad threshold and an
// active bit.
//
// The bank scans the processors round-robin. When a processor crosses its start
// or stop condition, the bank sends one event to the network. It then absorbs
// the token deltas that the network streams back, until the network signals done.
//
// Optional feature macro: TTT_BANK_TIMEOUT_EN
//    Defined   : a WAIT that lasts 1024 cycles without net_done is abandoned.
//                The sticky err flag is then raised.
//    Undefined : WAIT holds indefinitely and err is tied low.
//
// Ports
//    clk, reset           clock and synchronous active-high reset
//    run                  1 = scan/event mode, 0 = idle/programming mode
//    prog_header/data     programming command and payload (honoured only in IDLE)
//    ext_*                external token injection (accepted only while scanning)
//    net_valid_in,
//    net_source_id,
//    net_token_startstop  event issued to the network
//    net_valid_out,
//    net_target_id,
//    net_new_*_tokens,
//    net_done             token deltas streamed back by the network
//    busy                 high whenever the bank is not idle
//    err                  sticky timeout error
module ttt_processor_bank #(
   parameter int NUM_PROCESSORS  = 10,
   parameter int NEW_TOKENS_BITS = 4,
   parameter int TOKEN_BITS      = 8,
   parameter int PROG_WIDTH      = 8,
   localparam int IDW            = (NUM_PROCESSORS > 1) ? $clog2(NUM_PROCESSORS) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              run,
   input  logic [2:0]                        prog_header,
   input  logic [PROG_WIDTH-1:0]             prog_data,
   input  logic                              ext_valid,
   output logic                              ext_ready,
   input  logic [IDW-1:0]                    ext_target_id,
   input  logic signed [NEW_TOKENS_BITS-1:0] ext_good_tokens,
   input  logic signed [NEW_TOKENS_BITS-1:0] ext_bad_tokens,
   output logic                              net_valid_in,
   output logic [IDW-1:0]                    net_source_id,
   output logic [1:0]                        net_token_startstop,
   input  logic                              net_valid_out,
   input  logic [IDW-1:0]                    net_target_id,
   input  logic signed [NEW_TOKENS_BITS-1:0] net_new_good_tokens,
   input  logic signed [NEW_TOKENS_BITS-1:0] net_new_bad_tokens,
   input  logic                              net_done,
   output logic                              busy,
   output logic                              err
);

   localparam logic signed [TOKEN_BITS-1:0] TOK_MAX = {1'b0, {(TOKEN_BITS-1){1'b1}}};
   localparam logic signed [TOKEN_BITS-1:0] TOK_MIN = {1'b1, {(TOKEN_BITS-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_EMIT,
      S_WAIT
   } state_t;

   state_t                        state_q;
   logic [IDW-1:0]                scanIdx_q;
   logic [IDW-1:0]                src_q;
   logic [1:0]                    code_q;
   logic                          netValidIn_q;
   logic [1:0]                    startStop_q;
   logic                          busy_q;

   logic signed [TOKEN_BITS-1:0]  goodCnt_q [NUM_PROCESSORS];
   logic signed [TOKEN_BITS-1:0]  goodCnt_d [NUM_PROCESSORS];
   logic signed [TOKEN_BITS-1:0]  badCnt_q  [NUM_PROCESSORS];
   logic signed [TOKEN_BITS-1:0]  badCnt_d  [NUM_PROCESSORS];
   logic signed [TOKEN_BITS-1:0]  goodThr_q [NUM_PROCESSORS];
   logic signed [TOKEN_BITS-1:0]  goodThr_d [NUM_PROCESSORS];
   logic signed [TOKEN_BITS-1:0]  badThr_q  [NUM_PROCESSORS];
   logic signed [TOKEN_BITS-1:0]  badThr_d  [NUM_PROCESSORS];
   logic [NUM_PROCESSORS-1:0]     active_q;
   logic [NUM_PROCESSORS-1:0]     active_d;
   logic [IDW-1:0]                progPtr_q;
   logic [IDW-1:0]                progPtr_d;

   logic                          startCond;
   logic                          stopCond;
   logic                          evtFire;

   // Add a narrow signed delta to a counter. The sum is computed one bit wider,
   // so an overflow shows up as a disagreement between the top two bits and the
   // result can be clamped to the signed range instead of wrapping.
   function automatic logic signed [TOKEN_BITS-1:0] satAdd(
      input logic signed [TOKEN_BITS-1:0]      a,
      input logic signed [NEW_TOKENS_BITS-1:0] d
   );
      logic signed [TOKEN_BITS:0] sum;
      sum = (TOKEN_BITS+1)'(a) + (TOKEN_BITS+1)'(d);
      if (sum[TOKEN_BITS] != sum[TOKEN_BITS-1]) begin
         return sum[TOKEN_BITS] ? TOK_MIN : TOK_MAX;
      end
      return sum[TOKEN_BITS-1:0];
   endfunction

   // Step a processor index round-robin, wrapping from the last processor to 0.
   function automatic logic [IDW-1:0] nextIdx(input logic [IDW-1:0] idx);
      return (idx == IDW'(NUM_PROCESSORS - 1)) ? '0 : idx + IDW'(1);
   endfunction

   // Processor IDs can encode more values than there are processors.
   // Any ID outside the bank must be dropped, not written.
   function automatic logic inRange(input logic [IDW-1:0] idx);
      return int'(idx) < NUM_PROCESSORS;
   endfunction

   // Evaluate the processor currently under the scan pointer. Only one
   // processor is looked at per cycle, so changes to other processors are
   // picked up when the scan reaches them.
   always_comb begin
      startCond = !active_q[scanIdx_q]
                  && (goodCnt_q[scanIdx_q] >= goodThr_q[scanIdx_q])
                  && (badCnt_q[scanIdx_q] < badThr_q[scanIdx_q]);
      stopCond  = active_q[scanIdx_q]
                  && ((goodCnt_q[scanIdx_q] < goodThr_q[scanIdx_q])
                      || (badCnt_q[scanIdx_q] >= badThr_q[scanIdx_q]));
      evtFire   = (state_q == S_SCAN) && (startCond || stopCond);
   end

   // Next-state logic for the processor storage. The three update sources are
   // mutually exclusive by state:
   //    - programming happens in IDLE,
   //    - external injection and the active toggle happen in SCAN,
   //    - network deltas are applied in WAIT.
   // Keeping them exclusive means no write-port arbitration is needed.
   always_comb begin
      goodCnt_d = goodCnt_q;
      badCnt_d  = badCnt_q;
      goodThr_d = goodThr_q;
      badThr_d  = badThr_q;
      active_d  = active_q;
      progPtr_d = progPtr_q;
      case (state_q)
         S_IDLE: begin
            case (prog_header)
               3'b100: progPtr_d = prog_data[IDW-1:0];
               3'b101: begin
                  if (inRange(progPtr_q)) begin
                     goodThr_d[progPtr_q] = prog_data[TOKEN_BITS-1:0];
                  end
               end
               3'b110: begin
                  if (inRange(progPtr_q)) begin
                     badThr_d[progPtr_q] = prog_data[TOKEN_BITS-1:0];
                  end
                  progPtr_d = nextIdx(progPtr_q);
               end
               3'b111: begin
                  for (int i = 0; i < NUM_PROCESSORS; i++) begin
                     goodCnt_d[i] = '0;
                     badCnt_d[i]  = '0;
                  end
                  active_d = '0;
               end
               default: ;
            endcase
         end
         S_SCAN: begin
            if (ext_valid && inRange(ext_target_id)) begin
               goodCnt_d[ext_target_id] = satAdd(goodCnt_q[ext_target_id], ext_good_tokens);
               badCnt_d[ext_target_id]  = satAdd(badCnt_q[ext_target_id], ext_bad_tokens);
            end
            if (evtFire) begin
               active_d[scanIdx_q] = !active_q[scanIdx_q];
            end
         end
         S_WAIT: begin
            if (net_valid_out && inRange(net_target_id)) begin
               goodCnt_d[net_target_id] = satAdd(goodCnt_q[net_target_id], net_new_good_tokens);
               badCnt_d[net_target_id]  = satAdd(badCnt_q[net_target_id], net_new_bad_tokens);
            end
         end
         default: ;
      endcase
   end

   // Processor storage registers. After reset every threshold is 1, so a freshly
   // reset bank with all-zero counters never starts a processor on its own.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_PROCESSORS; i++) begin
            goodCnt_q[i] <= '0;
            badCnt_q[i]  <= '0;
            goodThr_q[i] <= TOKEN_BITS'(1);
            badThr_q[i]  <= TOKEN_BITS'(1);
         end
         active_q  <= '0;
         progPtr_q <= '0;
      end else begin
         goodCnt_q <= goodCnt_d;
         badCnt_q  <= badCnt_d;
         goodThr_q <= goodThr_d;
         badThr_q  <= badThr_d;
         active_q  <= active_d;
         progPtr_q <= progPtr_d;
      end
   end

`ifdef TTT_BANK_TIMEOUT_EN
   logic [15:0] waitCnt_q;
   logic        err_q;
`endif

   // Control state machine. All network-facing outputs are registered here, so
   // the event strobe appears exactly one cycle after the scan sees the condition.
   // The source and code are latched at that same moment.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         scanIdx_q    <= '0;
         src_q        <= '0;
         code_q       <= 2'b00;
         netValidIn_q <= 1'b0;
         startStop_q  <= 2'b00;
         busy_q       <= 1'b0;
`ifdef TTT_BANK_TIMEOUT_EN
         waitCnt_q    <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               netValidIn_q <= 1'b0;
               startStop_q  <= 2'b00;
               if (run) begin
                  state_q <= S_SCAN;
                  busy_q  <= 1'b1;
               end
            end
            S_SCAN: begin
               if (evtFire) begin
                  src_q        <= scanIdx_q;
                  code_q       <= startCond ? 2'b01 : 2'b10;
                  startStop_q  <= startCond ? 2'b01 : 2'b10;
                  netValidIn_q <= 1'b1;
                  state_q      <= S_EMIT;
               end else begin
                  scanIdx_q <= nextIdx(scanIdx_q);
                  if (!run) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            S_EMIT: begin
               netValidIn_q <= 1'b0;
               startStop_q  <= 2'b00;
               state_q      <= S_WAIT;
`ifdef TTT_BANK_TIMEOUT_EN
               waitCnt_q    <= '0;
`endif
            end
            S_WAIT: begin
               if (net_done) begin
                  scanIdx_q <= nextIdx(scanIdx_q);
                  state_q   <= run ? S_SCAN : S_IDLE;
                  busy_q    <= run;
               end
`ifdef TTT_BANK_TIMEOUT_EN
               else if (waitCnt_q == 16'd1023) begin
                  scanIdx_q <= nextIdx(scanIdx_q);
                  state_q   <= S_SCAN;
                  err_q     <= 1'b1;
               end else begin
                  waitCnt_q <= waitCnt_q + 16'd1;
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ext_ready           = (state_q == S_SCAN);
   assign net_valid_in        = netValidIn_q;
   assign net_source_id       = src_q;
   assign net_token_startstop = startStop_q;
   assign busy                = busy_q;

`ifdef TTT_BANK_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // code_q holds the last event code. It mirrors what was sent and is kept
   // for debug visibility. Fold it into a used signal so it is never dangling.
   logic unusedCode;
   assign unusedCode = ^code_q;

endmodule

// File: tb/tb_ttt_processor_bank.sv
// tb_ttt_processor_bank
// ---------------------
// Directed testbench for ttt_processor_bank.
//
// Each scenario task:
//    - drives its own stimulus,
//    - compares observed values against hand-computed expectations,
//    - reports every mismatch on a FAIL line.
// Scenarios run in order from one initial block, and the run ends with a
// single summary line.
//
// The timeout scenario follows TTT_BANK_TIMEOUT_EN, so the bench matches
// whichever build it is compiled with.
module tb_ttt_processor_bank;

   logic              clk = 1'b0;
   logic              reset;
   logic              run;
   logic [2:0]        prog_header;
   logic [7:0]        prog_data;
   logic              ext_valid;
   logic              ext_ready;
   logic [3:0]        ext_target_id;
   logic signed [3:0] ext_good_tokens;
   logic signed [3:0] ext_bad_tokens;
   logic              net_valid_in;
   logic [3:0]        net_source_id;
   logic [1:0]        net_token_startstop;
   logic              net_valid_out;
   logic [3:0]        net_target_id;
   logic signed [3:0] net_new_good_tokens;
   logic signed [3:0] net_new_bad_tokens;
   logic              net_done;
   logic              busy;
   logic              err;

   int total = 0;
   int bad   = 0;

   ttt_processor_bank dut (
      .clk                 (clk),
      .reset               (reset),
      .run                 (run),
      .prog_header         (prog_header),
      .prog_data           (prog_data),
      .ext_valid           (ext_valid),
      .ext_ready           (ext_ready),
      .ext_target_id       (ext_target_id),
      .ext_good_tokens     (ext_good_tokens),
      .ext_bad_tokens      (ext_bad_tokens),
      .net_valid_in        (net_valid_in),
      .net_source_id       (net_source_id),
      .net_token_startstop (net_token_startstop),
      .net_valid_out       (net_valid_out),
      .net_target_id       (net_target_id),
      .net_new_good_tokens (net_new_good_tokens),
      .net_new_bad_tokens  (net_new_bad_tokens),
      .net_done            (net_done),
      .busy                (busy),
      .err                 (err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Advance one clock. Inputs are driven, and outputs sampled, 1 ns after the
   // rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one programming command for a single cycle.
   task automatic progWrite(input logic [2:0] h, input logic [7:0] d);
      prog_header = h;
      prog_data   = d;
      tick();
      prog_header = 3'b000;
      prog_data   = 8'h00;
   endtask

   // Drive one external injection for a single cycle.
   task automatic inject(input logic [3:0] tgt, input logic signed [3:0] g,
                         input logic signed [3:0] b);
      ext_valid       = 1'b1;
      ext_target_id   = tgt;
      ext_good_tokens = g;
      ext_bad_tokens  = b;
      tick();
      ext_valid       = 1'b0;
      ext_target_id   = 4'd0;
      ext_good_tokens = 4'sd0;
      ext_bad_tokens  = 4'sd0;
   endtask

   // Wait up to 100 cycles for the event strobe.
   // Reports whether it was seen and after how many cycles.
   task automatic waitEvent(output bit seen, output int n);
      seen = 1'b0;
      n    = 0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (net_valid_in === 1'b1) begin
            seen = 1'b1;
            n    = i;
            break;
         end
      end
   endtask

   // Called one cycle after the strobe (EMIT).
   // Steps into WAIT, then finishes it with net_done.
   task automatic doneHandshake();
      tick();
      net_done = 1'b1;
      tick();
      net_done = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      total++; if (net_valid_in !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid_in: got %0d want 0", net_valid_in); end
      total++; if (net_source_id !== 4'd0) begin bad++; $display("[TB] FAIL reset_source_id: got %0d want 0", net_source_id); end
      total++; if (net_token_startstop !== 2'b00) begin bad++; $display("[TB] FAIL reset_startstop: got %b want 00", net_token_startstop); end
      total++; if (ext_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ext_ready: got %0d want 0", ext_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0d want 0", busy); end
      total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %0d want 0", err); end
      total++; if (dut.goodThr_q[3] !== 8'sd1) begin bad++; $display("[TB] FAIL reset_good_thr: got %0d want 1", dut.goodThr_q[3]); end
   endtask

   // Program processor 3, inject +2 good tokens, and expect a start event.
   // Timeline: the injection lands while processor 0 is scanned. Processor 3 is
   // then evaluated three cycles later, and the strobe appears right after that.
   task automatic test_start_event();
      bit seen;
      int n;
      progWrite(3'b100, 8'd3);
      progWrite(3'b101, 8'd2);
      progWrite(3'b110, 8'd1);
      run = 1'b1;
      tick();
      total++; if (ext_ready !== 1'b1) begin bad++; $display("[TB] FAIL scan_ext_ready: got %0d want 1", ext_ready); end
      total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL scan_busy: got %0d want 1", busy); end
      inject(4'd3, 4'sd2, 4'sd0);
      waitEvent(seen, n);
      total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL start_seen: got %0d want 1", seen); end
      total++; if (n != 3) begin bad++; $display("[TB] FAIL start_latency: got %0d want 3", n); end
      total++; if (net_source_id !== 4'd3) begin bad++; $display("[TB] FAIL start_src: got %0d want 3", net_source_id); end
      total++; if (net_token_startstop !== 2'b01) begin bad++; $display("[TB] FAIL start_code: got %b want 01", net_token_startstop); end
      total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL emit_busy: got %0d want 1", busy); end
      total++; if (ext_ready !== 1'b0) begin bad++; $display("[TB] FAIL emit_ext_ready: got %0d want 0", ext_ready); end
      tick();
      total++; if (net_valid_in !== 1'b0) begin bad++; $display("[TB] FAIL strobe_one_cycle: got %0d want 0", net_valid_in); end
      total++; if (net_token_startstop !== 2'b00) begin bad++; $display("[TB] FAIL wait_code: got %b want 00", net_token_startstop); end
   endtask

   // Stream two deltas back while in WAIT; the second one arrives with net_done.
   // Processor 5 (thr 1, good 3) starts first. After it, processor 3 stops
   // because bad = 1 has reached its bad threshold of 1.
   task automatic test_wait_deltas();
      bit seen;
      int n;
      net_valid_out       = 1'b1;
      net_target_id       = 4'd5;
      net_new_good_tokens = 4'sd3;
      net_new_bad_tokens  = 4'sd0;
      tick();
      net_target_id       = 4'd3;
      net_new_good_tokens = 4'sd0;
      net_new_bad_tokens  = 4'sd1;
      net_done            = 1'b1;
      tick();
      net_valid_out       = 1'b0;
      net_done            = 1'b0;
      net_new_bad_tokens  = 4'sd0;
      total++; if (dut.goodCnt_q[5] !== 8'sd3) begin bad++; $display("[TB] FAIL delta_good5: got %0d want 3", dut.goodCnt_q[5]); end
      total++; if (dut.badCnt_q[3] !== 8'sd1) begin bad++; $display("[TB] FAIL delta_bad3_with_done: got %0d want 1", dut.badCnt_q[3]); end
      total++; if (dut.goodCnt_q[3] !== 8'sd2) begin bad++; $display("[TB] FAIL delta_good3: got %0d want 2", dut.goodCnt_q[3]); end
      total++; if (ext_ready !== 1'b1) begin bad++; $display("[TB] FAIL done_back_to_scan: got %0d want 1", ext_ready); end
      waitEvent(seen, n);
      total++; if (seen !== 1'b1 || net_source_id !== 4'd5 || net_token_startstop !== 2'b01) begin
         bad++; $display("[TB] FAIL start5: got seen=%0d src=%0d code=%b want seen=1 src=5 code=01", seen, net_source_id, net_token_startstop);
      end
      doneHandshake();
      waitEvent(seen, n);
      total++; if (seen !== 1'b1 || net_source_id !== 4'd3 || net_token_startstop !== 2'b10) begin
         bad++; $display("[TB] FAIL stop3: got seen=%0d src=%0d code=%b want seen=1 src=3 code=10", seen, net_source_id, net_token_startstop);
      end
   endtask

   // Drop run in the middle of WAIT. The wait still completes on net_done and
   // the bank then goes idle. Programming is ignored while waiting and is
   // honoured once idle. Also checks that the programming pointer wraps from 9
   // back to 0.
   task automatic test_run_drop();
      tick();
      run         = 1'b0;
      prog_header = 3'b101;
      prog_data   = 8'd5;
      tick();
      prog_header = 3'b000;
      prog_data   = 8'd0;
      total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rundrop_busy: got %0d want 1", busy); end
      total++; if (dut.goodThr_q[4] !== 8'sd1) begin bad++; $display("[TB] FAIL prog_ignored_in_wait: got %0d want 1", dut.goodThr_q[4]); end
      net_done = 1'b1;
      tick();
      net_done = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rundrop_idle: got %0d want 0", busy); end
      total++; if (ext_ready !== 1'b0) begin bad++; $display("[TB] FAIL idle_ext_ready: got %0d want 0", ext_ready); end
      progWrite(3'b101, 8'd5);
      total++; if (dut.goodThr_q[4] !== 8'sd5) begin bad++; $display("[TB] FAIL prog_in_idle: got %0d want 5", dut.goodThr_q[4]); end
      progWrite(3'b100, 8'd9);
      progWrite(3'b110, 8'd3);
      progWrite(3'b101, 8'd7);
      total++; if (dut.badThr_q[9] !== 8'sd3) begin bad++; $display("[TB] FAIL bad_thr9: got %0d want 3", dut.badThr_q[9]); end
      total++; if (dut.goodThr_q[0] !== 8'sd7) begin bad++; $display("[TB] FAIL ptr_wrap: got %0d want 7", dut.goodThr_q[0]); end
   endtask

   // Force an event from processor 6 (good threshold 0), then reset while in
   // WAIT. Everything must come back to its reset values. A fresh run with no
   // injections must then stay silent.
   task automatic test_reset_mid_wait();
      bit seen;
      int n;
      int events;
      progWrite(3'b100, 8'd6);
      progWrite(3'b101, 8'd0);
      run = 1'b1;
      waitEvent(seen, n);
      total++; if (seen !== 1'b1 || net_source_id !== 4'd6) begin bad++; $display("[TB] FAIL start6: got seen=%0d src=%0d want seen=1 src=6", seen, net_source_id); end
      tick();
      reset = 1'b1;
      run   = 1'b0;
      tick();
      reset = 1'b0;
      total++; if (busy !== 1'b0 || ext_ready !== 1'b0 || net_valid_in !== 1'b0) begin
         bad++; $display("[TB] FAIL midreset_ctrl: got busy=%0d rdy=%0d vin=%0d want 0 0 0", busy, ext_ready, net_valid_in);
      end
      total++; if (net_source_id !== 4'd0 || net_token_startstop !== 2'b00 || err !== 1'b0) begin
         bad++; $display("[TB] FAIL midreset_out: got src=%0d code=%b err=%0d want 0 00 0", net_source_id, net_token_startstop, err);
      end
      total++; if (dut.goodCnt_q[5] !== 8'sd0 || dut.badCnt_q[3] !== 8'sd0) begin
         bad++; $display("[TB] FAIL midreset_counters: got g5=%0d b3=%0d want 0 0", dut.goodCnt_q[5], dut.badCnt_q[3]);
      end
      total++; if (dut.active_q !== 10'b0) begin bad++; $display("[TB] FAIL midreset_active: got %b want 0", dut.active_q); end
      total++; if (dut.goodThr_q[6] !== 8'sd1) begin bad++; $display("[TB] FAIL midreset_thr: got %0d want 1", dut.goodThr_q[6]); end
      run    = 1'b1;
      events = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (net_valid_in === 1'b1) events++;
      end
      total++; if (events != 0) begin bad++; $display("[TB] FAIL silent_after_reset: got %0d events want 0", events); end
      run = 1'b0;
      tick();
      tick();
   endtask

   // Processor 0 gets good threshold 127 and bad threshold -128, so it can
   // never start. Its counter must clamp at +127 going up and at -128 going
   // down. The clear command must then zero it.
   task automatic test_saturation();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      progWrite(3'b100, 8'd0);
      progWrite(3'b101, 8'd127);
      progWrite(3'b110, 8'h80);
      run = 1'b1;
      tick();
      total++; if (ext_ready !== 1'b1) begin bad++; $display("[TB] FAIL sat_ready: got %0d want 1", ext_ready); end
      for (int i = 0; i < 18; i++) inject(4'd0, 4'sd7, 4'sd0);
      total++; if (dut.goodCnt_q[0] !== 8'sd126) begin bad++; $display("[TB] FAIL sat_126: got %0d want 126", dut.goodCnt_q[0]); end
      for (int i = 0; i < 2; i++) inject(4'd0, 4'sd7, 4'sd0);
      total++; if (dut.goodCnt_q[0] !== 8'sd127) begin bad++; $display("[TB] FAIL sat_max: got %0d want 127", dut.goodCnt_q[0]); end
      for (int i = 0; i < 40; i++) inject(4'd0, 4'sh8, 4'sd0);
      total++; if (dut.goodCnt_q[0] !== 8'sh80) begin bad++; $display("[TB] FAIL sat_min: got %0d want -128", dut.goodCnt_q[0]); end
      run = 1'b0;
      tick();
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL sat_idle: got %0d want 0", busy); end
      progWrite(3'b111, 8'd0);
      total++; if (dut.goodCnt_q[0] !== 8'sd0) begin bad++; $display("[TB] FAIL clear_counters: got %0d want 0", dut.goodCnt_q[0]); end
   endtask

   // Withhold net_done after an event. WAIT must still be held after its
   // 1024th cycle begins. One cycle later, the timeout build returns to SCAN
   // with err set, while the default build keeps waiting.
   task automatic test_timeout();
      bit seen;
      int n;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      progWrite(3'b100, 8'd6);
      progWrite(3'b101, 8'd0);
      run = 1'b1;
      waitEvent(seen, n);
      total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL timeout_event: got %0d want 1", seen); end
      tick();
      for (int i = 0; i < 1023; i++) tick();
      total++; if (ext_ready !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("[TB] FAIL still_waiting: got rdy=%0d busy=%0d want 0 1", ext_ready, busy);
      end
      tick();
`ifdef TTT_BANK_TIMEOUT_EN
      total++; if (err !== 1'b1 || ext_ready !== 1'b1) begin
         bad++; $display("[TB] FAIL timeout_fire: got err=%0d rdy=%0d want 1 1", err, ext_ready);
      end
      for (int i = 0; i < 50; i++) tick();
      total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_sticky: got %0d want 1", err); end
`else
      total++; if (err !== 1'b0 || ext_ready !== 1'b0) begin
         bad++; $display("[TB] FAIL no_timeout: got err=%0d rdy=%0d want 0 0", err, ext_ready);
      end
      for (int i = 0; i < 50; i++) tick();
      total++; if (err !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("[TB] FAIL wait_holds: got err=%0d busy=%0d want 0 1", err, busy);
      end
`endif
      run   = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Scenario sequence.
   initial begin
      reset               = 1'b0;
      run                 = 1'b0;
      prog_header         = 3'b000;
      prog_data           = 8'h00;
      ext_valid           = 1'b0;
      ext_target_id       = 4'd0;
      ext_good_tokens     = 4'sd0;
      ext_bad_tokens      = 4'sd0;
      net_valid_out       = 1'b0;
      net_target_id       = 4'd0;
      net_new_good_tokens = 4'sd0;
      net_new_bad_tokens  = 4'sd0;
      net_done            = 1'b0;
      $display("[TB] starting ttt_processor_bank scenarios");
      test_reset();
      test_start_event();
      test_wait_deltas();
      test_run_drop();
      test_reset_mid_wait();
      test_saturation();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
